// File: rtl/muldiv_unit_pkg.sv
// Shared pipeline definitions for the iterative multiply/divide unit:
// op codes, FSM states and the buffer register that rides with an operation.
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PREP = 2'b01,
    ST_CALC = 2'b10,
    ST_FIN  = 2'b11
  } muldiv_state_e;

  // Latched op plus the sign correction FIN must apply.
  typedef struct packed {
    muldiv_op_e op;
    logic       neg;
  } muldiv_ctrl_t;

  function automatic logic op_is_div(input muldiv_op_e op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input muldiv_op_e op);
    return op[2] & op[1];
  endfunction

  function automatic logic op_signed_a(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_signed_b(input muldiv_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M-style multiply/divide: radix-2 shift-add multiply and
// restoring divide sharing one double-width accumulator, one bit per cycle.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Start,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] OperandA,
  input  logic [DATA_WIDTH-1:0] OperandB,
  input  logic                  Flush,
  output logic                  Busy,
  output logic                  Done,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Stall
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned AW    = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH) + 1;

  muldiv_state_e  state_q, state_d;
  muldiv_ctrl_t   ctrl_q;
  logic [W-1:0]   a_q, b_q;
  logic [AW-1:0]  acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]   result_q;
  logic           done_q, busy_q;

  logic           sign_a, sign_b, res_neg;
  logic [W-1:0]   a_abs, b_abs;
  logic           div_zero, div_ovf, special;
  logic [AW-1:0]  spec_acc;
  logic           calc_last;

  logic [W:0]     mul_sum;
  logic [AW-1:0]  mul_next;
  logic [W:0]     rem_shift;
  logic           div_ok;
  logic [W-1:0]   rem_sub;
  logic [AW-1:0]  div_next;

  logic [AW-1:0]  prod;
  logic [W-1:0]   quo, rem;
  logic [W-1:0]   fin_val;

  // Operand magnitudes, result sign and the cases that bypass CALC.
  always_comb begin
    sign_a   = op_signed_a(ctrl_q.op) & a_q[W-1];
    sign_b   = op_signed_b(ctrl_q.op) & b_q[W-1];
    a_abs    = sign_a ? W'(-a_q) : a_q;
    b_abs    = sign_b ? W'(-b_q) : b_q;
    res_neg  = op_is_rem(ctrl_q.op) ? sign_a : (sign_a ^ sign_b);
    div_zero = op_is_div(ctrl_q.op) && (b_q == '0);
    div_ovf  = ((ctrl_q.op == OP_DIV) || (ctrl_q.op == OP_REM)) &&
               (a_q == {1'b1, {(W-1){1'b0}}}) && (b_q == {W{1'b1}});
    special  = div_zero || div_ovf;
  end

  // Special results are placed in the accumulator half FIN reads for the op.
  always_comb begin
    spec_acc = '0;
    if (div_zero) begin
      spec_acc = op_is_rem(ctrl_q.op) ? {a_q, {W{1'b0}}} : {{W{1'b0}}, {W{1'b1}}};
    end else if (div_ovf && !op_is_rem(ctrl_q.op)) begin
      spec_acc = {{W{1'b0}}, a_q};
    end
  end

  assign calc_last = (cnt_q == CNT_W'(W - 1));

  // One shift-add step: conditional add into the high half, then shift right.
  always_comb begin
    mul_sum  = {1'b0, acc_q[AW-1:W]} + (acc_q[0] ? {1'b0, b_q} : {(W+1){1'b0}});
    mul_next = {mul_sum, acc_q[W-1:1]};
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_shift = acc_q[AW-1:W-1];
    div_ok    = (rem_shift >= {1'b0, b_q});
    rem_sub   = W'(rem_shift - {1'b0, b_q});
    div_next  = {(div_ok ? rem_sub : acc_q[AW-2:W-1]), acc_q[W-2:0], div_ok};
  end

  // Sign-corrected result selection.
  always_comb begin
    prod    = ctrl_q.neg ? AW'(-acc_q) : acc_q;
    quo     = ctrl_q.neg ? W'(-acc_q[W-1:0]) : acc_q[W-1:0];
    rem     = ctrl_q.neg ? W'(-acc_q[AW-1:W]) : acc_q[AW-1:W];
    fin_val = rem;
    case (ctrl_q.op)
      OP_MUL:                       fin_val = prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_val = prod[AW-1:W];
      OP_DIV, OP_DIVU:              fin_val = quo;
      default:                      fin_val = rem;
    endcase
  end

  // Next-state logic; Flush overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (Start) state_d = ST_PREP;
      ST_PREP: state_d = special ? ST_FIN : ST_CALC;
      ST_CALC: if (calc_last) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (Flush) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand latch, shared accumulator and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q   <= muldiv_ctrl_t'('0);
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      busy_q <= (state_d != ST_IDLE);
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start) begin
            ctrl_q.op  <= muldiv_op_e'(Funct3);
            ctrl_q.neg <= 1'b0;
            a_q        <= OperandA;
            b_q        <= OperandB;
          end
        end
        ST_PREP: begin
          b_q        <= b_abs;
          cnt_q      <= '0;
          ctrl_q.neg <= special ? 1'b0 : res_neg;
          acc_q      <= special ? spec_acc : {{W{1'b0}}, a_abs};
        end
        ST_CALC: begin
          acc_q <= op_is_div(ctrl_q.op) ? div_next : mul_next;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        ST_FIN: begin
          if (!Flush) begin
            result_q <= fin_val;
            done_q   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign Result = result_q;
  assign Stall  = rst && ((state_q == ST_IDLE && Start) ||
                          (state_q == ST_PREP) || (state_q == ST_CALC));

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at DATA_WIDTH=32: expected results are
// queued when an op is launched and popped when Done appears.
module tb_muldiv_unit;

  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
  localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

  logic        clk = 1'b0;
  logic        rst;
  logic        Start;
  logic [2:0]  Funct3;
  logic [31:0] OperandA, OperandB;
  logic        Flush;
  logic        Busy, Done, Stall;
  logic [31:0] Result;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_done  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp = 32'h0;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .Start(Start), .Funct3(Funct3),
    .OperandA(OperandA), .OperandB(OperandB), .Flush(Flush),
    .Busy(Busy), .Done(Done), .Result(Result), .Stall(Stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sa, sb, ub;
    logic [63:0]        p;
    logic signed [31:0] qa, qb, qr;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'h0, b};
    qa = a;
    qb = b;
    p  = 64'h0;
    qr = 32'sh0;
    case (f)
      F_MUL:    begin p = sa * sb; return p[31:0]; end
      F_MULH:   begin p = sa * sb; return p[63:32]; end
      F_MULHSU: begin p = sa * ub; return p[63:32]; end
      F_MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      F_DIV: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        qr = qa / qb;
        return qr;
      end
      F_DIVU:   return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      F_REM: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        qr = qa % qb;
        return qr;
      end
      default:  return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && ((b == 32'h0) ||
                    (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Result checker: every Done pops one expected value.
  always @(negedge clk) begin
    if (rst && Done) begin
      n_done++;
      if (exp_q.size() == 0) check("spurious_done", 64'd1, 64'd0);
      else check($sformatf("result_%0d", n_done), {32'h0, Result}, {32'h0, exp_q.pop_front()});
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Funct3 = f; OperandA = a; OperandB = b;
    @(posedge clk);
    @(negedge clk);
    Start = 1'b0; Funct3 = 3'($urandom); OperandA = $urandom; OperandB = $urandom;
  endtask

  task automatic issue(input string tag, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int k, st;
    exp_q.push_back(exp);
    last_exp = exp;
    launch(f, a, b);
    k = 0;
    st = 0;
    while (!Done && k < 100) begin
      if (Stall) st++;
      Start = (k == 5);
      @(negedge clk);
      k++;
    end
    Start = 1'b0;
    check({tag, "_lat"}, 64'(k), 64'(lat));
    check({tag, "_stall"}, 64'(st), 64'(lat - 1));
  endtask

  initial begin
    logic [2:0]  f;
    logic [31:0] a, b;
    rst = 1'b0; Start = 1'b0; Funct3 = 3'h0; OperandA = 32'h0; OperandB = 32'h0; Flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'h0, Busy}, 64'h0);
    check("rst_done", {63'h0, Done}, 64'h0);
    check("rst_stall", {63'h0, Stall}, 64'h0);
    check("rst_result", {32'h0, Result}, 64'h0);
    rst = 1'b1;
    @(negedge clk);

    issue("mul", F_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    issue("mulh", F_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    issue("mulhu", F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    issue("mulhsu", F_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34);
    issue("div", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    issue("rem", F_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    issue("divu_z", F_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    issue("remu_z", F_REMU, 32'd5, 32'd0, 32'd5, 2);
    issue("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    issue("rem_ovf", F_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 2);

    for (int i = 0; i < 12; i++) begin
      f = 3'($urandom_range(0, 7));
      a = (i % 3 == 0) ? 32'($urandom_range(0, 100)) : $urandom;
      b = (i % 4 == 1) ? 32'h0 : ((i % 3 == 2) ? 32'($urandom_range(1, 50)) : $urandom);
      issue($sformatf("rand%0d", i), f, a, b, ref_md(f, a, b), is_special(f, a, b) ? 2 : 34);
    end
    if (last_exp == 32'h0) issue("nonzero", F_MUL, 32'd9, 32'd11, 32'd99, 34);

    // Flush on the tenth CALC cycle.
    launch(F_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(negedge clk);
    check("flush_busy_before", {63'h0, Busy}, 64'h1);
    Flush = 1'b1;
    @(negedge clk);
    Flush = 1'b0;
    check("flush_busy", {63'h0, Busy}, 64'h0);
    check("flush_done", {63'h0, Done}, 64'h0);
    check("flush_hold", {32'h0, Result}, {32'h0, last_exp});
    repeat (40) @(negedge clk);
    check("flush_hold_late", {32'h0, Result}, {32'h0, last_exp});
    issue("mul_after_flush", F_MUL, 32'd3, 32'd4, 32'd12, 34);

    // Asynchronous reset in the middle of CALC.
    launch(F_DIVU, 32'hDEAD_BEEF, 32'd3);
    repeat (10) @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_result", {32'h0, Result}, 64'h0);
    check("arst_busy", {63'h0, Busy}, 64'h0);
    check("arst_stall", {63'h0, Stall}, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    issue("mul_after_rst", F_MUL, 32'd3, 32'd4, 32'd12, 34);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, operand and result width; legal values are powers of 2, >= 8.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port Start, input, 1 bit: request an operation; sampled only in IDLE.
REQ-005 The block SHALL have port Funct3, input, 3 bits: op select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 The block SHALL have ports OperandA and OperandB, input, DATA_WIDTH bits each: rs1 and rs2 values after forwarding.
REQ-007 The block SHALL have port Flush, input, 1 bit: abort the in-flight operation.
REQ-008 The block SHALL have port Busy, output, 1 bit: high when state is not IDLE.
REQ-009 The block SHALL have port Done, output, 1 bit: one-cycle pulse when Result is valid.
REQ-010 The block SHALL have port Result, output, DATA_WIDTH bits: last completed result, held until the next Done.
REQ-011 The block SHALL have port Stall, output, 1 bit: pipeline hold request.

Function
REQ-012 The state machine SHALL have states IDLE, PREP, CALC and FIN.
REQ-013 Transitions SHALL be: IDLE->PREP when Start=1; PREP->CALC normally, or PREP->FIN on a special case; CALC->FIN after exactly DATA_WIDTH iterations; FIN->IDLE unconditionally.
REQ-014 Funct3, OperandA and OperandB SHALL be latched on the IDLE edge that accepts Start; later changes to these inputs SHALL be ignored.
REQ-015 PREP SHALL take absolute values of signed operands (per op signedness), record the result sign, clear the iteration counter, and detect special cases.
REQ-016 Multiply SHALL be radix-2 shift-add, one bit per CALC cycle, producing a 2*DATA_WIDTH-bit product.
- MUL returns the low half of the product.
- MULH, MULHSU and MULHU return the high half.
REQ-017 Divide SHALL be restoring, one quotient bit per CALC cycle.
- DIV and DIVU return the quotient.
- REM and REMU return the remainder.
REQ-018 FIN SHALL apply sign correction: quotient sign = sign(A) XOR sign(B); remainder sign = sign(A); MULH and MULHSU product sign is negated as required.
REQ-019 In FIN, Result SHALL be registered and Done SHALL be 1 for exactly that cycle.
REQ-020 Normal latency: Done SHALL assert DATA_WIDTH+2 cycles after the Start-accepting edge (34 for DATA_WIDTH=32).
REQ-021 Divide by zero SHALL skip CALC, with Done 2 cycles after Start.
- DIV and DIVU return all-ones.
- REM and REMU return OperandA.
REQ-022 Signed overflow (DIV or REM with A = minimum signed value and B = -1) SHALL skip CALC.
- DIV returns the minimum signed value.
- REM returns 0.
REQ-023 Stall SHALL be (state==IDLE AND Start) OR state==PREP OR state==CALC; it is low in FIN so the pipeline advances with Done.
REQ-024 Start in PREP, CALC or FIN SHALL be ignored; no queuing.
REQ-025 Flush=1 in any state SHALL force IDLE on the next edge, with no Done and Result unchanged.
- Flush has priority over Start and over FIN completion.
REQ-026 Iteration counter width SHALL be $clog2(DATA_WIDTH)+1 bits; it never wraps within an operation.

Reset
REQ-027 While rst=0, the block SHALL hold state=IDLE, Busy=0, Done=0, Stall=0 and Result=0, and clear all internal registers.
REQ-028 Asserting rst mid-operation SHALL abandon the operation; after release the block accepts Start on the first rising edge.

Structure
REQ-029 The MulDivOp enum (8 Funct3 codes) and MulDivState enum SHALL be defined in the shared pipeline package alongside the buffer-register structs.
REQ-030 The block SHALL be one module with no sub-modules; the shift-add and restoring datapaths share one 2*DATA_WIDTH accumulator register.

Verification (DATA_WIDTH=32)
REQ-031 The bench SHALL cover MUL 7 x 0xFFFFFFFD -> Result 0xFFFFFFEB, with Done exactly 34 cycles after Start and Stall high for 33 cycles.
REQ-032 The bench SHALL cover MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-033 The bench SHALL cover DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD, and REM of the same operands -> 0xFFFFFFFF.
REQ-034 The bench SHALL cover divide by zero: DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, each with Done 2 cycles after Start.
REQ-035 The bench SHALL cover overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, each with Done 2 cycles after Start.
REQ-036 The bench SHALL cover aborts:
- Flush on CALC cycle 10 -> no Done, Busy=0 next cycle, Result keeps its prior value.
- rst=0 mid-CALC -> Result=0 immediately.
- A new MUL 3 x 4 after either abort -> 12.
